// File: rtl/mem_arb_pkg.sv
// Shared constants and FSM state encoding for the IC/DC line-burst memory arbiter.
package mem_arb_pkg;
    localparam int BEATS      = 8;
    localparam int LINE_OFS_W = 5;
    localparam int WORD_W     = 32;
    localparam int CNT_W      = LINE_OFS_W - 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IC_FILL = 3'd1,
        DC_FILL = 3'd2,
        DC_WB   = 3'd3,
        DONE    = 3'd4
    } state_t;
endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between IC and DC line requests; round-robin when MEM_ARB_RR_EN, else DC first.
// Latency: combinational select; the RR flag updates on the grant edge.
// Backpressure: none; the caller only consumes the result while idle.
module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic clk,
    input  logic reset,
    input  logic i_take,
`endif
    input  logic i_ic_req,
    input  logic i_dc_req,
    output logic o_gnt_any,
    output logic o_gnt_dc
);

    assign o_gnt_any = i_ic_req | i_dc_req;

`ifdef MEM_ARB_RR_EN
    logic r_last_dc;

    // On a tie the side that did not win last time goes first.
    assign o_gnt_dc = i_dc_req & ~(i_ic_req & r_last_dc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_dc <= 1'b0;
        end else if (i_take && o_gnt_any) begin
            r_last_dc <= o_gnt_dc;
        end
    end
`else
    assign o_gnt_dc = i_dc_req;
`endif

endmodule

// File: rtl/mem_arb.sv
// Arbitrates IC refills and DC refills/writebacks onto one single-word memory port (MEM_ARB_RR_EN: round-robin ties).
// Latency: grant one cycle after req, BEATS beat cycles at zero wait, one DONE cycle; read data registered one cycle.
// Backpressure: mem_ready low holds address/data and stalls the beat counter; requests wait in IDLE.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int BEATS  = 8,
    parameter int ADDR_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ic_req,
    input  logic [ADDR_W-1:0]         ic_addr,
    output logic [WORD_W-1:0]         ic_rdata,
    output logic                      ic_rvalid,
    output logic                      ic_done,
    input  logic                      dc_req,
    input  logic                      dc_is_wb,
    input  logic [ADDR_W-1:0]         dc_addr,
    input  logic [BEATS*WORD_W-1:0]   dc_wb_data,
    output logic [WORD_W-1:0]         dc_rdata,
    output logic                      dc_rvalid,
    output logic                      dc_done,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [WORD_W-1:0]         mem_wdata,
    input  logic                      mem_ready,
    input  logic [WORD_W-1:0]         mem_rdata,
    output logic                      busy
);

    state_t                         r_state;
    state_t                         w_next;
    logic [CNT_W-1:0]               r_cnt;
    logic [ADDR_W-LINE_OFS_W-1:0]   r_line;
    logic                           r_gnt_dc;
    logic [BEATS*WORD_W-1:0]        r_wb_data;
    logic [WORD_W-1:0]              r_ic_rdata;
    logic [WORD_W-1:0]              r_dc_rdata;
    logic                           r_ic_rvalid;
    logic                           r_dc_rvalid;
    logic                           w_gnt_any;
    logic                           w_gnt_dc;
    logic                           w_take;
    logic                           w_last_beat;
    logic                           w_unused_ofs;

    assign w_take       = (r_state == IDLE);
    assign w_last_beat  = (r_cnt == CNT_W'(BEATS - 1));
    assign w_unused_ofs = ^{ic_addr[LINE_OFS_W-1:0], dc_addr[LINE_OFS_W-1:0]};

    mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
        .clk       (clk),
        .reset     (reset),
        .i_take    (w_take),
`endif
        .i_ic_req  (ic_req),
        .i_dc_req  (dc_req),
        .o_gnt_any (w_gnt_any),
        .o_gnt_dc  (w_gnt_dc)
    );

    always_comb begin
        w_next  = r_state;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        busy    = 1'b1;
        ic_done = 1'b0;
        dc_done = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_gnt_any) begin
                    w_next = w_gnt_dc ? (dc_is_wb ? DC_WB : DC_FILL) : IC_FILL;
                end
            end
            IC_FILL, DC_FILL: begin
                mem_req = 1'b1;
                if (mem_ready && w_last_beat) w_next = DONE;
            end
            DC_WB: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready && w_last_beat) w_next = DONE;
            end
            DONE: begin
                ic_done = ~r_gnt_dc;
                dc_done = r_gnt_dc;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Address and write data come straight from registers so they stay put across stalls.
    assign mem_addr  = {r_line, r_cnt, 2'b00};
    assign mem_wdata = mem_we ? r_wb_data[r_cnt*WORD_W +: WORD_W] : '0;
    assign ic_rdata  = r_ic_rdata;
    assign dc_rdata  = r_dc_rdata;
    assign ic_rvalid = r_ic_rvalid;
    assign dc_rvalid = r_dc_rvalid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_line      <= '0;
            r_gnt_dc    <= 1'b0;
            r_wb_data   <= '0;
            r_ic_rdata  <= '0;
            r_dc_rdata  <= '0;
            r_ic_rvalid <= 1'b0;
            r_dc_rvalid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_ic_rvalid <= (r_state == IC_FILL) && mem_ready;
            r_dc_rvalid <= (r_state == DC_FILL) && mem_ready;
            if ((r_state == IC_FILL) && mem_ready) r_ic_rdata <= mem_rdata;
            if ((r_state == DC_FILL) && mem_ready) r_dc_rdata <= mem_rdata;
            if (w_take && w_gnt_any) begin
                r_line    <= w_gnt_dc ? dc_addr[ADDR_W-1:LINE_OFS_W] : ic_addr[ADDR_W-1:LINE_OFS_W];
                r_gnt_dc  <= w_gnt_dc;
                r_wb_data <= dc_wb_data;
            end
            if (mem_req && mem_ready) begin
                r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios with literal expectations plus randomized traffic against a beat-level model.
module tb_mem_arb;

    localparam int NB = 8;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          ic_req = 1'b0;
    logic [31:0]   ic_addr = '0;
    logic          dc_req = 1'b0;
    logic          dc_is_wb = 1'b0;
    logic [31:0]   dc_addr = '0;
    logic [255:0]  dc_wb_data = '0;
    logic          mem_ready = 1'b0;
    logic [31:0]   mem_rdata;
    logic [31:0]   ic_rdata, dc_rdata, mem_addr, mem_wdata;
    logic          ic_rvalid, ic_done, dc_rvalid, dc_done, mem_req, mem_we, busy;

    mem_arb #(.BEATS(NB), .ADDR_W(32)) dut (
        .clk(clk), .reset(rst_n),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid), .ic_done(ic_done),
        .dc_req(dc_req), .dc_is_wb(dc_is_wb), .dc_addr(dc_addr), .dc_wb_data(dc_wb_data),
        .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_done(dc_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction
    assign mem_rdata = memfn(mem_addr);

    int checks = 0;
    int fails  = 0;
    bit chk_en = 1'b0;
    bit stop   = 1'b0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got=%0b expected=%0b at %0t", nm, act, exp, $time);
        end
    endtask

    // Beat-level model: one burst = NB accepted beats at base+4*i, then a single done cycle.
    logic         m_act, m_done, m_dc, m_wb, m_last_dc, m_ic_rv, m_dc_rv;
    int           m_beat;
    logic [31:0]  m_base, m_rdata;
    logic [255:0] m_wbd;
    logic         m_pick_dc;
    assign m_pick_dc = dc_req && !(RR && ic_req && m_last_dc);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act <= 1'b0; m_done <= 1'b0; m_dc <= 1'b0; m_wb <= 1'b0; m_last_dc <= 1'b0;
            m_ic_rv <= 1'b0; m_dc_rv <= 1'b0; m_beat <= 0; m_base <= '0; m_rdata <= '0; m_wbd <= '0;
        end else begin
            m_ic_rv <= m_act && !m_wb && !m_dc && mem_ready;
            m_dc_rv <= m_act && !m_wb && m_dc && mem_ready;
            if (m_act && !m_wb && mem_ready) m_rdata <= memfn(m_base + 32'(4 * m_beat));
            if (m_act) begin
                if (mem_ready) begin
                    if (m_beat == NB - 1) begin
                        m_act <= 1'b0; m_done <= 1'b1; m_beat <= 0;
                    end else begin
                        m_beat <= m_beat + 1;
                    end
                end
            end else if (m_done) begin
                m_done <= 1'b0;
            end else if (ic_req || dc_req) begin
                m_act     <= 1'b1;
                m_dc      <= m_pick_dc;
                m_last_dc <= m_pick_dc;
                m_wb      <= m_pick_dc && dc_is_wb;
                m_base    <= m_pick_dc ? {dc_addr[31:5], 5'b0} : {ic_addr[31:5], 5'b0};
                m_wbd     <= dc_wb_data;
                m_beat    <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chkb("busy", busy, m_act || m_done);
            chkb("mem_req", mem_req, m_act);
            chkb("mem_we", mem_we, m_act && m_wb);
            chk32("mem_wdata", mem_wdata, (m_act && m_wb) ? m_wbd[32*m_beat +: 32] : 32'h0);
            if (m_act) chk32("mem_addr", mem_addr, m_base + 32'(4 * m_beat));
            chkb("ic_rvalid", ic_rvalid, m_ic_rv);
            chkb("dc_rvalid", dc_rvalid, m_dc_rv);
            if (m_ic_rv) chk32("ic_rdata", ic_rdata, m_rdata);
            if (m_dc_rv) chk32("dc_rdata", dc_rdata, m_rdata);
            chkb("ic_done", ic_done, m_done && !m_dc);
            chkb("dc_done", dc_done, m_done && m_dc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ic_side();
        int t;
        while (!stop) begin
            repeat (1 + $urandom_range(0, 4)) @(posedge clk);
            #1;
            ic_addr = $urandom;
            ic_req  = 1'b1;
            t = 0;
            while (!(m_act && !m_dc) && t < 3000) begin @(negedge clk); t++; end
            chkb("ic_grant_timeout", t < 3000, 1'b1);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; ic_req = 1'b0; end
            t = 0;
            while (!ic_done && t < 200) begin @(negedge clk); t++; end
            chkb("ic_done_timeout", t < 200, 1'b1);
            ic_req = 1'b0;
        end
    endtask

    task automatic dc_side();
        int t;
        while (!stop) begin
            repeat (1 + $urandom_range(0, 3)) @(posedge clk);
            #1;
            dc_addr  = $urandom;
            dc_is_wb = 1'($urandom_range(0, 1));
            for (int i = 0; i < NB; i++) dc_wb_data[32*i +: 32] = $urandom;
            dc_req = 1'b1;
            t = 0;
            while (!(m_act && m_dc) && t < 3000) begin @(negedge clk); t++; end
            chkb("dc_grant_timeout", t < 3000, 1'b1);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; dc_req = 1'b0; end
            t = 0;
            while (!dc_done && t < 200) begin @(negedge clk); t++; end
            chkb("dc_done_timeout", t < 200, 1'b1);
            dc_req = 1'b0;
        end
    endtask

    task automatic ready_drv();
        while (!stop) begin
            @(posedge clk);
            #1;
            mem_ready = ($urandom_range(0, 3) != 0);
        end
        mem_ready = 1'b1;
    endtask

    initial begin
        int n, n_rv, n_done, k, cnt;
        logic [31:0] first_a, last_a, stall_a;
        logic order0, order1, reraise, reraise_dc;

        // Reset values
        repeat (3) tick();
        chk_en = 1'b1;
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_mem_req", mem_req, 1'b0);
        chkb("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk32("rst_ic_rdata", ic_rdata, 32'h0);
        chk32("rst_dc_rdata", dc_rdata, 32'h0);
        chkb("rst_rvalid", ic_rvalid | dc_rvalid, 1'b0);
        chkb("rst_done", ic_done | dc_done, 1'b0);
        rst_n = 1'b1;
        tick();

        // Simultaneous requests, twice back to back
        mem_ready = 1'b1; ic_addr = 32'h2000; dc_addr = 32'h3000; dc_is_wb = 1'b0;
        ic_req = 1'b1; dc_req = 1'b1;
        cnt = 0; order0 = 1'b0; order1 = 1'b0; reraise = 1'b0; reraise_dc = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (reraise) begin
                if (reraise_dc) dc_req = 1'b1; else ic_req = 1'b1;
                reraise = 1'b0;
            end
            if (ic_done || dc_done) begin
                if (cnt == 0) order0 = dc_done;
                if (cnt == 1) order1 = dc_done;
                cnt++;
                if (cnt == 1) begin
                    reraise = 1'b1; reraise_dc = dc_done;
                    if (dc_done) dc_req = 1'b0; else ic_req = 1'b0;
                end else begin
                    ic_req = 1'b0; dc_req = 1'b0;
                end
            end
        end
        chk32("tie_grants", 32'(cnt), 32'd2);
        chkb("tie_first_dc", order0, 1'b1);
        chkb("tie_second_dc", order1, !RR);

        // Zero-wait IC refill
        ic_addr = 32'h0000_1234; ic_req = 1'b1;
        n = 0; n_rv = 0; n_done = 0; first_a = '0; last_a = '0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (mem_req) begin
                if (n == 0) first_a = mem_addr;
                last_a = mem_addr;
                n++;
            end
            if (ic_rvalid) n_rv++;
            if (ic_done) begin n_done++; ic_req = 1'b0; end
        end
        chk32("ic_beat_cycles", 32'(n), 32'd8);
        chk32("ic_first_addr", first_a, 32'h1220);
        chk32("ic_last_addr", last_a, 32'h123C);
        chk32("ic_rvalid_cnt", 32'(n_rv), 32'd8);
        chk32("ic_done_cnt", 32'(n_done), 32'd1);
        chkb("ic_idle_after", busy, 1'b0);

        // DC writeback
        dc_addr = 32'h0040_0020; dc_is_wb = 1'b1;
        for (int i = 0; i < NB; i++) dc_wb_data[32*i +: 32] = 32'(32'hA0 + i);
        dc_req = 1'b1;
        n = 0; n_rv = 0; n_done = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (mem_req) begin
                chkb("wb_we", mem_we, 1'b1);
                chk32("wb_wdata", mem_wdata, 32'(32'hA0 + n));
                chk32("wb_addr", mem_addr, 32'(32'h0040_0020 + 4 * n));
                n++;
            end
            if (dc_rvalid) n_rv++;
            if (dc_done) begin n_done++; dc_req = 1'b0; end
        end
        chk32("wb_beats", 32'(n), 32'd8);
        chk32("wb_rvalid_cnt", 32'(n_rv), 32'd0);
        chk32("wb_done_cnt", 32'(n_done), 32'd1);
        dc_is_wb = 1'b0;

        // Three stall cycles on beat 2
        ic_addr = 32'h0000_5000; ic_req = 1'b1;
        tick();
        k = 0; n_rv = 0; n_done = 0; stall_a = '0;
        for (int c = 0; c < 30; c++) begin
            if (ic_rvalid) n_rv++;
            if (ic_done) begin n_done++; ic_req = 1'b0; end
            if (mem_req) begin
                mem_ready = !(k >= 2 && k <= 4);
                if (k == 3) stall_a = mem_addr;
                k++;
            end else begin
                mem_ready = 1'b1;
            end
            tick();
        end
        mem_ready = 1'b1;
        chk32("stall_cycles", 32'(k), 32'd11);
        chk32("stall_addr", stall_a, 32'h5008);
        chk32("stall_rvalid_cnt", 32'(n_rv), 32'd8);
        chk32("stall_done_cnt", 32'(n_done), 32'd1);

        // Reset during beat 4 of a DC refill
        dc_addr = 32'h0000_8000; dc_req = 1'b1;
        tick();
        repeat (4) tick();
        chk32("abort_beat4_addr", mem_addr, 32'h8010);
        rst_n = 1'b0;
        #1;
        chkb("abort_mem_req", mem_req, 1'b0);
        chkb("abort_busy", busy, 1'b0);
        chkb("abort_dc_rvalid", dc_rvalid, 1'b0);
        dc_req = 1'b0;
        tick();
        rst_n = 1'b1;
        ic_addr = 32'h0000_9000; ic_req = 1'b1;
        n = 0; n_rv = 0; n_done = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (dc_done) n++;
            if (ic_rvalid) n_rv++;
            if (ic_done) begin n_done++; ic_req = 1'b0; end
        end
        chk32("abort_no_dc_done", 32'(n), 32'd0);
        chk32("abort_ic_rvalid_cnt", 32'(n_rv), 32'd8);
        chk32("abort_ic_done_cnt", 32'(n_done), 32'd1);

        // Request dropped at beat 1
        dc_addr = 32'h0000_C000; dc_req = 1'b1;
        n = 0; n_done = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (mem_req) n++;
            if (n == 2) dc_req = 1'b0;
            if (dc_done) n_done++;
        end
        chk32("drop_beats", 32'(n), 32'd8);
        chk32("drop_done_cnt", 32'(n_done), 32'd1);

        // Randomized traffic
        fork
            ic_side();
            dc_side();
            ready_drv();
            begin repeat (4000) @(posedge clk); stop = 1'b1; end
        join
        ic_req = 1'b0; dc_req = 1'b0; mem_ready = 1'b1;
        repeat (15) tick();
        chkb("final_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter BEATS, default 8: words per cache-line burst (32-byte line).
REQ-002 Parameter ADDR_W, default 32: byte-address width.
REQ-003 Port clk, input, 1: the single clock; all state on posedge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port ic_req, input, 1: instruction-cache line-refill request, held until ic_done.
REQ-006 Port ic_addr, input, ADDR_W: IC line address; bits [4:0] ignored.
REQ-007 Port ic_rdata/ic_rvalid/ic_done, output, 32/1/1: refill word, word strobe, burst-complete pulse.
REQ-008 Port dc_req, input, 1: data-cache request (refill or writeback), held until dc_done.
REQ-009 Port dc_is_wb, input, 1: 1 = writeback of dc_wb_data, 0 = refill.
REQ-010 Port dc_addr, input, ADDR_W: DC line address; bits [4:0] ignored.
REQ-011 Port dc_wb_data, input, 256: dirty line; word i = bits [32*i+31:32*i].
REQ-012 Port dc_rdata/dc_rvalid/dc_done, output, 32/1/1: as REQ-007, for DC.
REQ-013 Port mem_req/mem_we/mem_addr/mem_wdata, output, 1/1/ADDR_W/32: single-word memory port.
REQ-014 Port mem_ready/mem_rdata, input, 1/32: beat accept, read data valid with mem_ready.
REQ-015 Port busy, output, 1: high in any non-IDLE state.

Function
REQ-016 FSM states IDLE, IC_FILL, DC_FILL, DC_WB, DONE; 3-bit beat counter.
REQ-017 Requests sampled only in IDLE; a grant latches addr[ADDR_W-1:5], dc_is_wb and dc_wb_data.
REQ-018 IDLE -> DC_WB if dc_req&dc_is_wb, DC_FILL if dc_req&~dc_is_wb, else IC_FILL if ic_req.
REQ-019 Beat i: mem_addr = {latched line, i[2:0], 2'b00}; mem_we=1 and mem_wdata=word i only in DC_WB.
REQ-020 mem_req high throughout burst states; mem_addr/mem_wdata stable until mem_ready sampled high, then counter increments.
REQ-021 Fill beats: rdata <= mem_rdata, rvalid <= 1 on the granted side, registered (one cycle after the mem_ready edge); rvalid otherwise 0.
REQ-022 After beat BEATS-1 accepted, counter wraps to 0 and FSM enters DONE; done pulses 1 cycle in DONE, mem_req=0.
REQ-023 DONE -> IDLE unconditionally; requester drops req during DONE; no grant possible before the next IDLE cycle.
REQ-024 req deassertion mid-burst ignored; burst completes.
REQ-025 Writeback and refill of the same miss are two separate DC requests (wb then fill).
REQ-026 mem_ready while mem_req=0 ignored; zero-wait memory (mem_ready tied 1) gives BEATS-cycle bursts.

Reset
REQ-027 reset low: state IDLE, counter 0, mem_req/mem_we/busy/rvalid/done = 0, rdata/mem_addr/mem_wdata = 0.
REQ-028 Reset mid-burst aborts immediately; no done pulse; partial data discarded.

Configuration
REQ-029 Macro MEM_ARB_RR_EN defined: round-robin on simultaneous ic_req/dc_req; side not last granted wins; last-granted flag resets to IC.
REQ-030 Macro absent: fixed priority DC over IC (REQ-018); IC may starve.

Structure
REQ-031 Package mem_arb_pkg: state enum, BEATS, LINE_OFS_W=5, WORD_W=32.
REQ-032 One sub-module mem_arb_pick: combinational winner select plus RR flag register (flag only under MEM_ARB_RR_EN).

Verification
REQ-033 ic_req, ic_addr=0x0000_1234, mem_ready=1 -> mem_addr 0x1220..0x123C in 8 cycles, 8 ic_rvalid, ic_done once, IDLE.
REQ-034 dc_req, dc_is_wb=1, dc_addr=0x0040_0020, wb words 0..7=0xA0..0xA7 -> 8 writes, mem_wdata 0xA0..0xA7 at 0x400020..0x40003C, dc_done, no dc_rvalid.
REQ-035 ic_req and dc_req same cycle, twice back-to-back -> no macro: DC,DC; with MEM_ARB_RR_EN: DC then IC.
REQ-036 mem_ready low 3 cycles on beat 2 -> mem_addr held at beat-2 address, total fill 11 cycles, data order intact.
REQ-037 reset asserted at beat 4 of DC_FILL -> mem_req=0 same cycle, no dc_done, next ic_req served normally.
REQ-038 dc_req dropped at beat 1 -> burst runs all 8 beats and dc_done pulses.
